// File: rtl/fib_pkg.sv
// Shared types and seed constants for the Fibonacci/Lucas sequence calculator.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    FIB   = 1'b0,
    LUCAS = 1'b1
  } mode_e;

  // Sequence seeds: term 0 and term 1.
  localparam int unsigned FIB_S0 = 0;
  localparam int unsigned FIB_S1 = 1;
  localparam int unsigned LUC_S0 = 2;
  localparam int unsigned LUC_S1 = 1;

endpackage

// File: rtl/fib_sat_adder.sv
// Combinational W-bit saturating adder: clamps to all-ones and flags carry on overflow.
module fib_sat_adder #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] full;

  // Widen by one bit so the carry out is visible, then saturate on it.
  always_comb begin
    full  = {1'b0, a} + {1'b0, b};
    carry = full[W];
    sum   = full[W] ? {W{1'b1}} : full[W-1:0];
  end

endmodule

// File: rtl/fib_seq_calculator.sv
// Iterative Fibonacci/Lucas term calculator with saturation and a sticky overflow flag.
// Latency is n+1 cycles from the accepting edge regardless of data.
module fib_seq_calculator
  import fib_pkg::*;
#(
  parameter int unsigned W   = 16,
  parameter int unsigned N_W = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N_W-1:0] input_s,
  input  logic           begin_fibo,
  input  logic           mode,
  output logic           done,
  output logic           busy,
  output logic [W-1:0]   fibo_out,
  output logic           overflow
);

  state_e         state_q, state_d;
  logic [N_W-1:0] n_q, n_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           ovf_a_q, ovf_a_d;
  logic           ovf_b_q, ovf_b_d;
  logic [W-1:0]   fibo_q, fibo_d;
  logic           ovf_out_q, ovf_out_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;

  logic [W-1:0]   sum;
  logic           carry;

  fib_sat_adder #(
    .W (W)
  ) u_add (
    .a     (a_q),
    .b     (b_q),
    .sum   (sum),
    .carry (carry)
  );

  // Next-state logic: accept starts in IDLE/DONE, step a/b in CALC, publish result at n=0.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    a_d       = a_q;
    b_d       = b_q;
    ovf_a_d   = ovf_a_q;
    ovf_b_d   = ovf_b_q;
    fibo_d    = fibo_q;
    ovf_out_d = ovf_out_q;
    done_d    = done_q;
    busy_d    = busy_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (begin_fibo) begin
          n_d     = input_s;
          a_d     = (mode == LUCAS) ? W'(LUC_S0) : W'(FIB_S0);
          b_d     = (mode == LUCAS) ? W'(LUC_S1) : W'(FIB_S1);
          ovf_a_d = 1'b0;
          ovf_b_d = 1'b0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (n_q != '0) begin
          // b runs one term ahead; its overflow only reaches the result once shifted into a.
          a_d     = b_q;
          ovf_a_d = ovf_b_q;
          b_d     = sum;
          ovf_b_d = ovf_a_q | ovf_b_q | carry;
          n_d     = n_q - N_W'(1);
        end else begin
          fibo_d    = a_q;
          ovf_out_d = ovf_a_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      n_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      ovf_a_q   <= 1'b0;
      ovf_b_q   <= 1'b0;
      fibo_q    <= '0;
      ovf_out_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ovf_a_q   <= ovf_a_d;
      ovf_b_q   <= ovf_b_d;
      fibo_q    <= fibo_d;
      ovf_out_q <= ovf_out_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign done     = done_q;
  assign busy     = busy_q;
  assign fibo_out = fibo_q;
  assign overflow = ovf_out_q;

endmodule
